// File: rtl/decode_issue_queue_pkg.sv
// Types shared by the decode/issue path: the decoded instruction and one queue entry.
// An entry is the decoded instruction plus the branch id it was fetched under.
package decode_issue_queue_pkg;

    localparam int BID_W = 2;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [9:0] imm;
    } decoded_instr;

    localparam int DATA_W = $bits(decoded_instr);

    typedef struct packed {
        decoded_instr          instr;
        logic [BID_W-1:0]      bid;
    } iq_entry_t;

    function automatic iq_entry_t pack_entry(input logic [DATA_W-1:0] d,
                                             input logic [BID_W-1:0]  b);
        iq_entry_t e;
        e.instr = decoded_instr'(d);
        e.bid   = b;
        return e;
    endfunction

endpackage

// File: rtl/decode_issue_queue.sv
// Dual-push/dual-pop in-order queue between decode and rename; push visible 1 cycle later.
// ready_o needs >= 2 free slots from the registered count; pushes while not ready are dropped and flagged.
module decode_issue_queue
    import decode_issue_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       valid_i1,
    input  logic [DATA_W-1:0]          data_i1,
    input  logic [BID_W-1:0]           bid_i1,
    input  logic                       valid_i2,
    input  logic [DATA_W-1:0]          data_i2,
    input  logic [BID_W-1:0]           bid_i2,
    output logic                       ready_o,
    output logic                       valid_o1,
    output logic [DATA_W-1:0]          data_o1,
    output logic [BID_W-1:0]           bid_o1,
    output logic                       valid_o2,
    output logic [DATA_W-1:0]          data_o2,
    output logic [BID_W-1:0]           bid_o2,
    input  logic                       pop_1,
    input  logic                       pop_2,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

    iq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, head_p1, tail_p1;
    logic [CNT_W-1:0] count_q, count_d, n_push, n_pop;
    logic             overflow_q, overflow_d;
    logic             push_req, push_ok, wr0_en, wr1_en;
    iq_entry_t        wr0_ent, wr1_ent;

    assign head_p1 = head_q + PTR_W'(1);
    assign tail_p1 = tail_q + PTR_W'(1);

    assign ready_o    = (count_q <= READY_MAX);
    assign valid_o1   = (count_q != '0);
    assign valid_o2   = (count_q >= CNT_W'(2));
    assign {data_o1, bid_o1} = mem_q[head_q];
    assign {data_o2, bid_o2} = mem_q[head_p1];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

    // Compaction: first valid input always lands at tail, so a lone slot-2 push fills tail.
    always_comb begin
        push_req = valid_i1 | valid_i2;
        push_ok  = push_req & ready_o;
        wr0_en   = push_ok;
        wr1_en   = push_ok & valid_i1 & valid_i2;
        wr0_ent  = valid_i1 ? pack_entry(data_i1, bid_i1) : pack_entry(data_i2, bid_i2);
        wr1_ent  = pack_entry(data_i2, bid_i2);
        n_push   = push_ok ? (CNT_W'(valid_i1) + CNT_W'(valid_i2)) : '0;
        n_pop    = (pop_1 & valid_o1) ? (CNT_W'(1) + CNT_W'(pop_2 & valid_o2)) : '0;
    end

    always_comb begin
        head_d     = head_q + PTR_W'(n_pop);
        tail_d     = tail_q + PTR_W'(n_push);
        count_d    = count_q + n_push - n_pop;
        overflow_d = overflow_q | (push_req & ~ready_o);
        if (flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is intentionally not reset; valid outputs mask stale contents.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (wr0_en) mem_q[tail_q]  <= wr0_ent;
            if (wr1_en) mem_q[tail_p1] <= wr1_ent;
        end
    end

endmodule
